// File: rtl/car_ctrl_pkg.sv
// Shared definitions for the car-control slice: turn-indicator FSM states,
// default remote command codes and the downstream indication encoding.
package car_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEFT     = 3'd1,
        ST_RIGHT    = 3'd2,
        ST_TO_LEFT  = 3'd3,
        ST_TO_RIGHT = 3'd4
    } turn_state_t;

    localparam logic [7:0] CMD_LEFT_DFLT   = 8'h4C;
    localparam logic [7:0] CMD_RIGHT_DFLT  = 8'h52;
    localparam logic [7:0] CMD_CANCEL_DFLT = 8'h46;

    localparam int unsigned TMR_W = 8;

    localparam logic [1:0] IND_NONE  = 2'b00;
    localparam logic [1:0] IND_LEFT  = 2'b10;
    localparam logic [1:0] IND_RIGHT = 2'b01;

    // Transition states report the direction being switched to.
    function automatic logic [1:0] ind_of(input turn_state_t st);
        logic [1:0] ind;
        case (st)
            ST_LEFT, ST_TO_LEFT:   ind = IND_LEFT;
            ST_RIGHT, ST_TO_RIGHT: ind = IND_RIGHT;
            default:               ind = IND_NONE;
        endcase
        return ind;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that saturates at zero; flags zero for the turn FSM.
module tick_timer
    import car_ctrl_pkg::*;
(
    input  logic             clk_mid,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [TMR_W-1:0] load_val,
    output logic             zero
);

    logic [TMR_W-1:0] count_q;
    logic [TMR_W-1:0] count_d;

    // Next count: load wins over decrement, decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != {TMR_W{1'b0}})) begin
            count_d = count_q - {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_mid or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {TMR_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == {TMR_W{1'b0}});

endmodule

// File: rtl/turn_req_gen.sv
// Turns remote steering commands into one-cycle indicator request pulses,
// with a one-cycle stop gap on direction changes and an inactivity auto-cancel.
module turn_req_gen
    import car_ctrl_pkg::*;
#(
    parameter int         TIMEOUT_TICKS = 24,
    parameter logic [7:0] CMD_LEFT      = CMD_LEFT_DFLT,
    parameter logic [7:0] CMD_RIGHT     = CMD_RIGHT_DFLT,
    parameter logic [7:0] CMD_CANCEL    = CMD_CANCEL_DFLT
) (
    input  logic       clk_mid,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [7:0] cmd,
    output logic       left_light,
    output logic       right_light,
    output logic       stop,
    output logic [1:0] ind_state,
    output logic       cmd_err,
    output logic       cmd_drop
);

    localparam logic [TMR_W-1:0] LOAD_VAL = TMR_W'(TIMEOUT_TICKS - 1);

    turn_state_t state_q, state_d;
    logic        left_q, left_d, right_q, right_d, stop_q, stop_d;
    logic        err_q, err_d, drop_q, drop_d;
    logic [1:0]  ind_q, ind_d;
    logic        tmr_load, tmr_dec, tmr_zero;
    logic        is_left, is_right, is_cancel;

    assign is_left   = (cmd == CMD_LEFT);
    assign is_right  = (cmd == CMD_RIGHT);
    assign is_cancel = (cmd == CMD_CANCEL);

    tick_timer u_tick_timer (
        .clk_mid  (clk_mid),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .dec      (tmr_dec),
        .load_val (LOAD_VAL),
        .zero     (tmr_zero)
    );

    // Next-state and response-pulse decode; a command beats a zero timer.
    always_comb begin
        state_d  = state_q;
        left_d   = 1'b0;
        right_d  = 1'b0;
        stop_d   = 1'b0;
        err_d    = 1'b0;
        drop_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (is_left) begin
                        left_d   = 1'b1;
                        state_d  = ST_LEFT;
                        tmr_load = 1'b1;
                    end else if (is_right) begin
                        right_d  = 1'b1;
                        state_d  = ST_RIGHT;
                        tmr_load = 1'b1;
                    end else if (is_cancel) begin
                        state_d = ST_IDLE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LEFT, ST_RIGHT: begin
                if (cmd_valid) begin
                    if (is_cancel) begin
                        stop_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (is_left || is_right) begin
                        if ((state_q == ST_LEFT) == is_left) begin
                            tmr_load = 1'b1;
                        end else begin
                            stop_d  = 1'b1;
                            state_d = is_left ? ST_TO_LEFT : ST_TO_RIGHT;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (tmr_zero) begin
                    stop_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_TO_LEFT, ST_TO_RIGHT: begin
                // Single-cycle gap: incoming commands are discarded here.
                drop_d   = cmd_valid;
                tmr_load = 1'b1;
                if (state_q == ST_TO_LEFT) begin
                    left_d  = 1'b1;
                    state_d = ST_LEFT;
                end else begin
                    right_d = 1'b1;
                    state_d = ST_RIGHT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ind_d = ind_of(state_d);
    end

    // State and registered output flops.
    always_ff @(posedge clk_mid or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            stop_q  <= 1'b0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            ind_q   <= IND_NONE;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            right_q <= right_d;
            stop_q  <= stop_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            ind_q   <= ind_d;
        end
    end

    assign left_light  = left_q;
    assign right_light = right_q;
    assign stop        = stop_q;
    assign ind_state   = ind_q;
    assign cmd_err     = err_q;
    assign cmd_drop    = drop_q;

endmodule

// File: tb/tb_turn_req_gen.sv
// Directed bench for turn_req_gen: inputs driven and outputs sampled on the
// falling edge, expected values hand-computed per scenario.
module tb_turn_req_gen;

    logic       clk_mid;
    logic       rst_n;
    logic       cmd_valid;
    logic [7:0] cmd;
    logic       left_light, right_light, stop, cmd_err, cmd_drop;
    logic [1:0] ind_state;

    int n_vec;
    int n_err;

    turn_req_gen dut (
        .clk_mid     (clk_mid),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .left_light  (left_light),
        .right_light (right_light),
        .stop        (stop),
        .ind_state   (ind_state),
        .cmd_err     (cmd_err),
        .cmd_drop    (cmd_drop)
    );

    initial begin
        clk_mid = 1'b0;
        forever #5 clk_mid = ~clk_mid;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Outputs packed as {left, right, stop, ind[1:0], err, drop}.
    task automatic expect_out(input string tag, input logic l, input logic r, input logic s,
                              input logic [1:0] ind, input logic e, input logic d);
        check_vec(tag, {25'd0, left_light, right_light, stop, ind_state, cmd_err, cmd_drop},
                       {25'd0, l, r, s, ind, e, d});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_mid);
    endtask

    // Present a command for one rising edge; returns in the response cycle.
    task automatic strobe(input logic [7:0] c);
        cmd_valid = 1'b1;
        cmd       = c;
        @(negedge clk_mid);
        cmd_valid = 1'b0;
        cmd       = 8'h00;
    endtask

    // Direction/stop exclusivity watched every cycle.
    always @(negedge clk_mid) begin
        check_vec("excl", {30'd0, stop & (left_light | right_light), left_light & right_light}, 32'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd       = 8'h00;
        tick(2);
        expect_out("reset", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        rst_n = 1'b1;

        // First command after reset honoured; timeout fires 24 cycles later.
        strobe(8'h4C);
        expect_out("left_pulse", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        for (int k = 1; k <= 23; k++) begin
            tick(1);
            expect_out("left_hold", 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        end
        tick(1);
        expect_out("timeout_stop", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        tick(1);
        expect_out("idle_after_to", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Left to right change goes through the stop gap.
        strobe(8'h4C);
        expect_out("left_pulse2", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        tick(3);
        strobe(8'h52);
        expect_out("chg_stop", 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        tick(1);
        expect_out("chg_right", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);

        // Periodic refresh keeps RIGHT alive.
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < 9; j++) begin
                tick(1);
                expect_out("refresh_hold", 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
            end
            strobe(8'h52);
            expect_out("refresh_cmd", 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 23; k++) begin
            tick(1);
            expect_out("refresh_tail", 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        end
        tick(1);
        expect_out("refresh_stop", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);

        // Unknown code in IDLE, then a command dropped during TO_RIGHT.
        strobe(8'h00);
        expect_out("err_idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        tick(1);
        expect_out("err_clear", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        strobe(8'h4C);
        expect_out("left_pulse3", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        strobe(8'h52);
        expect_out("to_right_stop", 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
        strobe(8'h4C);
        expect_out("drop_in_to", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1);
        tick(1);
        expect_out("after_drop", 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0);
        strobe(8'hA5);
        expect_out("err_right", 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0);
        strobe(8'h46);
        expect_out("cancel_right", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        strobe(8'h46);
        expect_out("cancel_idle", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Cancel on the zero cycle: single stop.
        strobe(8'h4C);
        expect_out("left_pulse4", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        tick(23);
        strobe(8'h46);
        expect_out("zero_cancel", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
        tick(1);
        expect_out("zero_cancel_1", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1);
        expect_out("zero_cancel_2", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Same-direction refresh on the zero cycle reloads instead of stopping.
        strobe(8'h4C);
        expect_out("left_pulse5", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        tick(23);
        strobe(8'h4C);
        expect_out("zero_reload", 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        for (int k = 1; k <= 23; k++) begin
            tick(1);
            expect_out("reload_hold", 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        end
        tick(1);
        expect_out("reload_stop", 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);

        // Reset mid-indication clears outputs at once, no stop afterwards.
        strobe(8'h4C);
        expect_out("left_pulse6", 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        tick(5);
        #2 rst_n = 1'b0;
        #1 expect_out("async_rst", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        tick(1);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            expect_out("post_rst", 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        strobe(8'h52);
        expect_out("post_rst_cmd", 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
